// File: rtl/conv_sequencer_if.sv
// Channel between the convolution sequencer and its environment: the shared
// filter-engine request/response handshake and the output-buffer write port.
interface conv_sequencer_if #(
  parameter int NUM_FILTERS = 16,
  parameter int INPUT_SIZE  = 28,
  parameter int FILTER_SIZE = 7,
  parameter int STRIDE      = 2
);
  localparam int OUT_SIZE = (INPUT_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int TOTAL    = NUM_FILTERS * OUT_SIZE * OUT_SIZE;
  localparam int FW       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int PW       = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int AW       = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  logic          eng_req_valid;
  logic          eng_req_ready;
  logic [FW-1:0] eng_filt;
  logic [PW-1:0] eng_win_row;
  logic [PW-1:0] eng_win_col;
  logic          eng_rsp_valid;
  logic [31:0]   eng_rsp_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  modport master (
    output eng_req_valid, eng_filt, eng_win_row, eng_win_col,
    output wr_en, wr_addr, wr_data,
    input  eng_req_ready, eng_rsp_valid, eng_rsp_data
  );

  modport slave (
    input  eng_req_valid, eng_filt, eng_win_row, eng_win_col,
    input  wr_en, wr_addr, wr_data,
    output eng_req_ready, eng_rsp_valid, eng_rsp_data
  );
endinterface

// File: rtl/conv_sequencer.sv
// Walks every (filter, out_row, out_col) position of a conv layer, issues one
// window request at a time to the shared engine and writes each result out.
module conv_sequencer #(
  parameter int NUM_FILTERS = 16,
  parameter int INPUT_SIZE  = 28,
  parameter int FILTER_SIZE = 7,
  parameter int STRIDE      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  conv_sequencer_if.master bus
);
  localparam int OUT_SIZE = (INPUT_SIZE - FILTER_SIZE) / STRIDE + 1;
  localparam int TOTAL    = NUM_FILTERS * OUT_SIZE * OUT_SIZE;
  localparam int FW       = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
  localparam int PW       = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
  localparam int AW       = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  localparam logic [FW-1:0] FILT_LAST = FW'(NUM_FILTERS - 1);
  localparam logic [PW-1:0] POS_LAST  = PW'(OUT_SIZE - 1);
  localparam logic [PW-1:0] WIN_STEP  = PW'(STRIDE);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_t;

  state_t        state_reg;
  logic [FW-1:0] filt_reg;
  logic [PW-1:0] row_reg;
  logic [PW-1:0] col_reg;
  logic [PW-1:0] win_row_reg;
  logic [PW-1:0] win_col_reg;
  logic [AW-1:0] addr_reg;
  logic          req_valid_reg;
  logic          wr_en_reg;
  logic          done_reg;
  logic [31:0]   wr_data_reg;

  logic filt_last;
  logic row_last;
  logic col_last;

  assign filt_last = (filt_reg == FILT_LAST);
  assign row_last  = (row_reg == POS_LAST);
  assign col_last  = (col_reg == POS_LAST);

  assign busy              = (state_reg != IDLE);
  assign done              = done_reg;
  assign bus.eng_req_valid = req_valid_reg;
  assign bus.eng_filt      = filt_reg;
  assign bus.eng_win_row   = win_row_reg;
  assign bus.eng_win_col   = win_col_reg;
  assign bus.wr_en         = wr_en_reg;
  assign bus.wr_addr       = addr_reg;
  assign bus.wr_data       = wr_data_reg;

  // Window origins and the flat address are kept as running counters that
  // step alongside the position counters, so no multiplier is needed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      filt_reg      <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      win_row_reg   <= '0;
      win_col_reg   <= '0;
      addr_reg      <= '0;
      req_valid_reg <= 1'b0;
      wr_en_reg     <= 1'b0;
      done_reg      <= 1'b0;
      wr_data_reg   <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= ISSUE;
            req_valid_reg <= 1'b1;
            filt_reg      <= '0;
            row_reg       <= '0;
            col_reg       <= '0;
            win_row_reg   <= '0;
            win_col_reg   <= '0;
            addr_reg      <= '0;
          end
        end
        ISSUE: begin
          if (abort) begin
            state_reg     <= IDLE;
            req_valid_reg <= 1'b0;
          end else if (bus.eng_req_ready) begin
            state_reg     <= WAIT;
            req_valid_reg <= 1'b0;
          end
        end
        WAIT: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (bus.eng_rsp_valid) begin
            state_reg   <= WRITE;
            wr_data_reg <= bus.eng_rsp_data;
            wr_en_reg   <= 1'b1;
          end
        end
        WRITE: begin
          if (abort) begin
            state_reg <= IDLE;
          end else if (filt_last && row_last && col_last) begin
            state_reg <= IDLE;
            done_reg  <= 1'b1;
          end else begin
            state_reg     <= ISSUE;
            req_valid_reg <= 1'b1;
            addr_reg      <= addr_reg + AW'(1);
            if (col_last) begin
              col_reg     <= '0;
              win_col_reg <= '0;
              if (row_last) begin
                row_reg     <= '0;
                win_row_reg <= '0;
                filt_reg    <= filt_reg + FW'(1);
              end else begin
                row_reg     <= row_reg + PW'(1);
                win_row_reg <= win_row_reg + WIN_STEP;
              end
            end else begin
              col_reg     <= col_reg + PW'(1);
              win_col_reg <= win_col_reg + WIN_STEP;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule
